uart_msg_scheduler: RTL

- Transmit-side controller for the multiplayer UART link.
- Collects game-event requests from the local player: ready, took a hit, and lost.
- Queues the requests, arbitrates them by fixed priority, and sequences one ASCII command byte at a time into the shared UART transmitter using a start/busy handshake.
- Emits the byte codes that the peer's receive-side decoder recognises, and is active only in multiplayer mode.

---
 rtl/uart_msg_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_msg_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_msg_scheduler
//  Description : Transmit-side controller for the multiplayer UART link.
//                Queues ready / hit / lost game events, arbitrates them by
//                fixed priority (LOST > HIT > READY) and hands one ASCII
//                command byte at a time to the shared UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_scheduler #(
    parameter logic [7:0] CHAR_LOST     = 8'h4C,
    parameter logic [7:0] CHAR_HIT      = 8'h44,
    parameter logic [7:0] CHAR_READY    = 8'h52,
    parameter int         GAP_CYCLES    = 16,
    parameter int         START_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       multiplayer,
    input  logic       req_ready,
    input  logic       req_hit,
    input  logic       req_lost,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       pend_ready,
    output logic       pend_lost,
    output logic [3:0] hit_count,
    output logic       hit_overflow,
    output logic       game_over_sent
);

    // One counter serves both the start timeout and the inter-byte gap.
    localparam int C_CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [C_CW-1:0] r_cnt;
    logic [C_CW-1:0] w_cnt_next;
    logic            w_grant_lost;
    logic            w_grant_hit;
    logic            w_grant_ready;
    logic            w_grant_any;
    logic            w_pending;
    logic            w_hit_inc;

    assign w_pending   = pend_lost | pend_ready | (hit_count != 4'd0);
    assign w_grant_any = w_grant_lost | w_grant_hit | w_grant_ready;
    assign w_hit_inc   = multiplayer & req_hit;

    // State and shared counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and arbitration; arbitration happens only in IDLE.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_grant_lost  = 1'b0;
        w_grant_hit   = 1'b0;
        w_grant_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (multiplayer && !game_over_sent && w_pending) begin
                    w_state_next = S_LOAD;
                    if (pend_lost)
                        w_grant_lost = 1'b1;
                    else if (hit_count != 4'd0)
                        w_grant_hit = 1'b1;
                    else
                        w_grant_ready = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_next = S_WAIT_BUSY;
                w_cnt_next   = '0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_cnt == C_CW'(START_TIMEOUT - 1)) begin
                    // UART never acknowledged: treat the byte as sent.
                    w_state_next = S_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + C_CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_next = S_GAP;
                    w_cnt_next   = '0;
                end
            end
            S_GAP: begin
                if (r_cnt == C_CW'(GAP_CYCLES - 1))
                    w_state_next = S_IDLE;
                else
                    w_cnt_next = r_cnt + C_CW'(1);
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Transmit strobe and data; data is held for the whole byte, zeroed on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= w_grant_any;
            if (w_grant_lost)
                tx_data <= CHAR_LOST;
            else if (w_grant_hit)
                tx_data <= CHAR_HIT;
            else if (w_grant_ready)
                tx_data <= CHAR_READY;
            else if (w_state_next == S_IDLE && r_state != S_IDLE)
                tx_data <= 8'h00;
        end
    end

    // Request capture: set beats clear, simultaneous hit inc/dec cancel out.
    always_ff @(posedge clk) begin
        if (rst || !multiplayer) begin
            pend_ready     <= 1'b0;
            pend_lost      <= 1'b0;
            hit_count      <= 4'd0;
            hit_overflow   <= 1'b0;
            game_over_sent <= 1'b0;
        end else begin
            pend_ready     <= req_ready | (pend_ready & ~w_grant_ready);
            pend_lost      <= req_lost  | (pend_lost  & ~w_grant_lost);
            game_over_sent <= game_over_sent | w_grant_lost;
            if (w_hit_inc && !w_grant_hit) begin
                if (hit_count == 4'd15)
                    hit_overflow <= 1'b1;
                else
                    hit_count <= hit_count + 4'd1;
            end else if (!w_hit_inc && w_grant_hit) begin
                hit_count <= hit_count - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire
